// File: rtl/alu_seq_pkg.sv
// Shared types for alu_seq: opcodes, control states and the bit positions inside the {V,N,Z,C} flag word.
package alu_seq_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SHL = 3'b101,
      OP_SHR = 3'b110,
      OP_MUL = 3'b111
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } alu_state_e;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, done after WIDTH iterations.
module alu_mul_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_start,
   input  logic [WIDTH-1:0]     i_a,
   input  logic [WIDTH-1:0]     i_b,
   output logic                 o_done,
   output logic [2*WIDTH-1:0]   o_prod
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_END = CW'(WIDTH);

   logic                 r_busy;
   logic [CW-1:0]        r_cnt;
   logic [2*WIDTH-1:0]   r_mcand;
   logic [WIDTH-1:0]     r_mplier;
   logic [2*WIDTH-1:0]   r_acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
      end else if (i_start) begin
         r_busy   <= 1'b1;
         r_cnt    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, i_a};
         r_mplier <= i_b;
         r_acc    <= '0;
      end else if (r_busy) begin
         if (r_cnt != CNT_END) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
         end else begin
            // Product is taken by the parent on this edge; go quiet.
            r_busy <= 1'b0;
         end
      end
   end

   assign o_done = r_busy && (r_cnt == CNT_END);
   assign o_prod = r_acc;

endmodule

// File: rtl/alu_seq.sv
// Handshaked registered ALU with flags and shifts; the iterative multiplier is built only when ALU_SEQ_MUL_EN is defined.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic [3:0]       flags
);

   localparam int SHW = $clog2(WIDTH);

   alu_state_e       r_state, w_state_nxt;
   alu_op_e          w_op;
   logic [WIDTH-1:0] r_result, r_result_hi, w_res;
   logic [3:0]       r_flags, w_flags;
   logic [WIDTH:0]   w_ext;
   logic [SHW-1:0]   w_sh;
   logic             w_c, w_v;
   logic             w_accept, w_out_xfer, w_is_mul, w_mul_done;

   assign w_op       = alu_op_e'(op);
   assign w_sh       = b[SHW-1:0];
   assign out_valid  = (r_state == ST_DONE);
   assign in_ready   = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_out_xfer = out_valid && out_ready;

`ifdef ALU_SEQ_MUL_EN
   logic [2*WIDTH-1:0] w_prod;
   logic [3:0]         w_mflags;

   assign w_is_mul = (w_op == OP_MUL);

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_start (w_accept && w_is_mul),
      .i_a     (a),
      .i_b     (b),
      .o_done  (w_mul_done),
      .o_prod  (w_prod)
   );

   always_comb begin
      w_mflags         = '0;
      w_mflags[FLAG_V] = |w_prod[2*WIDTH-1:WIDTH];
      w_mflags[FLAG_N] = w_prod[WIDTH-1];
      w_mflags[FLAG_Z] = (w_prod[WIDTH-1:0] == '0);
   end
`else
   assign w_is_mul   = 1'b0;
   assign w_mul_done = 1'b0;
`endif

   // Single-cycle datapath; op 111 falls through to zero when not multiplied.
   always_comb begin
      w_res = '0;
      w_ext = '0;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (w_op)
         OP_ADD: begin
            w_ext = {1'b0, a} + {1'b0, b};
            w_res = w_ext[WIDTH-1:0];
            w_c   = w_ext[WIDTH];
            w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUB: begin
            w_ext = {1'b0, a} - {1'b0, b};
            w_res = w_ext[WIDTH-1:0];
            w_c   = w_ext[WIDTH];
            w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_res[WIDTH-1] != a[WIDTH-1]);
         end
         OP_AND: w_res = a & b;
         OP_OR:  w_res = a | b;
         OP_XOR: w_res = a ^ b;
         OP_SHL: begin
            w_ext = {1'b0, a} << w_sh;
            w_res = w_ext[WIDTH-1:0];
            w_c   = w_ext[WIDTH];
         end
         OP_SHR: begin
            w_ext = {a, 1'b0} >> w_sh;
            w_res = w_ext[WIDTH:1];
            w_c   = w_ext[0];
         end
         default: w_res = '0;
      endcase
      w_flags         = '0;
      w_flags[FLAG_C] = w_c;
      w_flags[FLAG_Z] = (w_res == '0);
      w_flags[FLAG_N] = w_res[WIDTH-1];
      w_flags[FLAG_V] = w_v;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_accept)        w_state_nxt = w_is_mul ? ST_BUSY : ST_DONE;
            else if (w_out_xfer) w_state_nxt = ST_IDLE;
         end
         ST_BUSY: if (w_mul_done) w_state_nxt = ST_DONE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_result    <= '0;
         r_result_hi <= '0;
         r_flags     <= '0;
      end else if (w_accept && !w_is_mul) begin
         r_result    <= w_res;
         r_result_hi <= '0;
         r_flags     <= w_flags;
      end
`ifdef ALU_SEQ_MUL_EN
      else if ((r_state == ST_BUSY) && w_mul_done) begin
         r_result    <= w_prod[WIDTH-1:0];
         r_result_hi <= w_prod[2*WIDTH-1:WIDTH];
         r_flags     <= w_mflags;
      end
`endif
   end

   assign result    = r_result;
   assign result_hi = r_result_hi;
   assign flags     = r_flags;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=8; multiplier scenarios follow ALU_SEQ_MUL_EN.
module tb_alu_seq;
   import alu_seq_pkg::*;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a, b;
   logic [2:0]   op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result, result_hi;
   logic [3:0]   flags;

   int n_chk  = 0;
   int n_pass = 0;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .op        (op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .result_hi (result_hi),
      .flags     (flags)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
      in_valid = 1'b1;
      op = o; a = x; b = y;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic expect_out(input string tag, input logic [W-1:0] r, input logic [W-1:0] rh,
                             input logic [3:0] f);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_res"},   32'(result),    32'(r));
      check({tag, "_hi"},    32'(result_hi), 32'(rh));
      check({tag, "_flags"}, 32'(flags),     32'(f));
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_res"},   32'(result),    32'd0);
      check({tag, "_hi"},    32'(result_hi), 32'd0);
      check({tag, "_flags"}, 32'(flags),     32'd0);
      check({tag, "_ready"}, 32'(in_ready),  32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
      $fatal(1);
   end

   initial begin
      int bad;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = 3'b000; a = '0; b = '0;
      repeat (2) tick();
      check_cleared("reset");
      rst_n = 1'b1;
      tick();
      check("post_reset_ready", 32'(in_ready), 32'd1);

      issue(OP_ADD, 8'hFF, 8'h01); expect_out("add_carry", 8'h00, 8'h00, 4'b0011);
      issue(OP_SUB, 8'h80, 8'h01); expect_out("sub_ovf",   8'h7F, 8'h00, 4'b1000);
      issue(OP_SHL, 8'h81, 8'h01); expect_out("shl1",      8'h02, 8'h00, 4'b0001);
      issue(OP_SHR, 8'h81, 8'h00); expect_out("shr0",      8'h81, 8'h00, 4'b0100);
      issue(OP_SUB, 8'h01, 8'h02); expect_out("sub_borrow",8'hFF, 8'h00, 4'b0101);
      issue(OP_ADD, 8'h7F, 8'h01); expect_out("add_ovf",   8'h80, 8'h00, 4'b1100);
      issue(OP_AND, 8'hF0, 8'h3C); expect_out("and",       8'h30, 8'h00, 4'b0000);
      issue(OP_OR,  8'hF0, 8'h0C); expect_out("or",        8'hFC, 8'h00, 4'b0100);
      issue(OP_XOR, 8'hAA, 8'hAA); expect_out("xor_zero",  8'h00, 8'h00, 4'b0010);
      issue(OP_SHR, 8'h81, 8'h01); expect_out("shr1",      8'h40, 8'h00, 4'b0001);
      issue(OP_SHL, 8'h81, 8'h09); expect_out("shl_wrap",  8'h02, 8'h00, 4'b0001);
      issue(OP_SHL, 8'h01, 8'h07); expect_out("shl7",      8'h80, 8'h00, 4'b0100);

`ifdef ALU_SEQ_MUL_EN
      issue(OP_MUL, 8'h10, 8'h20);
      bad = 0;
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      repeat (W) begin
         tick();
         if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      end
      check("mul_busy_cycles", 32'(bad), 32'd0);
      tick();
      expect_out("mul_10x20", 8'h00, 8'h02, 4'b1010);
      issue(OP_MUL, 8'hFF, 8'hFF);
      repeat (W) tick();
      check("mul_ff_early", 32'(out_valid), 32'd0);
      tick();
      expect_out("mul_ffxff", 8'h01, 8'hFE, 4'b1000);
      issue(OP_ADD, 8'h01, 8'h01); expect_out("add_after_mul", 8'h02, 8'h00, 4'b0000);
`else
      issue(OP_MUL, 8'h10, 8'h20); expect_out("mul_off", 8'h00, 8'h00, 4'b0010);
`endif
      tick();
      check("idle_drain", 32'(out_valid), 32'd0);

      out_ready = 1'b0;
      in_valid = 1'b1; op = OP_ADD; a = 8'h01; b = 8'h02;
      tick();
      check("bp_first_valid", 32'(out_valid), 32'd1);
      check("bp_first_res", 32'(result), 32'h03);
      a = 8'h10; b = 8'h20;
      bad = 0;
      repeat (4) begin
         tick();
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 8'h03) bad++;
      end
      check("bp_hold", 32'(bad), 32'd0);
      out_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(in_ready), 32'd1);
      check("bp_release_res", 32'(result), 32'h03);
      tick();
      check("bp_second_res", 32'(result), 32'h30);
      check("bp_second_valid", 32'(out_valid), 32'd1);
      a = 8'h40; b = 8'h05;
      tick();
      in_valid = 1'b0;
      check("bp_third_res", 32'(result), 32'h45);
      tick();
      check("bp_drain", 32'(out_valid), 32'd0);

`ifdef ALU_SEQ_MUL_EN
      issue(OP_MUL, 8'h10, 8'h20);
      repeat (3) tick();
      rst_n = 1'b0;
      #1;
      check_cleared("rst_mid_mul");
`else
      out_ready = 1'b0;
      issue(OP_ADD, 8'h07, 8'h08);
      check("rst_held_res", 32'(result), 32'h0F);
      tick();
      rst_n = 1'b0;
      #1;
      check_cleared("rst_mid_hold");
      out_ready = 1'b1;
`endif
      tick();
      rst_n = 1'b1;
      check("rst_release_ready", 32'(in_ready), 32'd1);
      issue(OP_ADD, 8'h02, 8'h03); expect_out("add_after_rst", 8'h05, 8'h00, 4'b0000);
      repeat (W + 3) tick();
      check("no_stale_result", 32'(out_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
